// File: rtl/y_ctrl_pkg.sv
// Shared types and constants for the y_ctrl multi-cycle control sequencer.
// Included by the decoder, the FSM and the bench.
package y_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_BEQ  = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] op;
        logic       mem2reg;
        logic       regwr_en;
        logic       is_mem;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       is_jal;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/y_ctrl_fsm_if.sv
// Bus between the control sequencer (master) and the yIF..yWB datapath (slave).
// Carries the instruction and branch/jump inputs, plus every control output.
interface y_ctrl_fsm_if #(parameter int XLEN = 32);
    logic            run;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jTarget;
    logic            zero;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic            RegWrite;
    logic            ALUSrc;
    logic            MemRead;
    logic            MemWrite;
    logic            Mem2Reg;
    logic [2:0]      op;
    logic [2:0]      state;
    logic            retired;
    logic            illegal;

    modport master (
        input  run, ins, imm, jTarget, zero,
        output pc, ir, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, state, retired, illegal
    );

    modport slave (
        output run, ins, imm, jTarget, zero,
        input  pc, ir, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, state, retired, illegal
    );
endinterface

// File: rtl/y_ctrl_decode.sv
// Combinational opcode/funct3 decoder for the RV32 subset handled by y_ctrl_fsm.
// Unknown opcodes return safe defaults with illegal raised.
module y_ctrl_decode
    import y_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output dec_t       dec
);
    always_comb begin
        dec         = '0;
        dec.alu_src = 1'b1;
        dec.op      = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec.alu_src  = 1'b0;
                dec.regwr_en = 1'b1;
                if (funct3 == 3'b110)      dec.op = ALU_OR;
                else if (funct3 == 3'b111) dec.op = ALU_AND;
            end
            OP_ADDI: dec.regwr_en = 1'b1;
            OP_LW: begin
                dec.mem2reg  = 1'b1;
                dec.regwr_en = 1'b1;
                dec.is_mem   = 1'b1;
                dec.is_lw    = 1'b1;
            end
            OP_SW: begin
                dec.is_mem = 1'b1;
                dec.is_sw  = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_src = 1'b0;
                dec.op      = ALU_SUB;
                dec.is_beq  = 1'b1;
            end
            OP_JAL: begin
                dec.regwr_en = 1'b1;
                dec.is_jal   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/y_ctrl_fsm.sv
// Multi-cycle control sequencer: owns pc/ir, steps FETCH..WB per instruction
// and drives registered datapath controls aligned with the reported state.
module y_ctrl_fsm
    import y_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] ENTRY_PC = 'h28
) (
    input logic          clk,
    input logic          rst_n,
    y_ctrl_fsm_if.master bus
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, ir_q, pc_nxt;
    logic            zero_q;
    logic            alu_src_q, mem2reg_q, regwrite_q, memread_q, memwrite_q;
    logic            retired_q, illegal_q;
    logic [2:0]      op_q;
    dec_t            dec;

    y_ctrl_decode u_decode (
        .opcode (ir_q[6:0]),
        .funct3 (ir_q[14:12]),
        .dec    (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec.illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = dec.is_mem ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = bus.run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc_q + XLEN'(4);
        if (dec.is_beq && zero_q) pc_nxt = pc_q + (bus.imm << 1);
        else if (dec.is_jal)      pc_nxt = pc_q + (bus.jTarget << 2);
    end

    // Strobes are computed from state_d so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= ENTRY_PC;
            ir_q       <= '0;
            zero_q     <= 1'b0;
            alu_src_q  <= 1'b1;
            op_q       <= ALU_ADD;
            mem2reg_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            retired_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) ir_q <= bus.ins;
            if (state_q == S_DECODE) begin
                if (dec.illegal) begin
                    illegal_q <= 1'b1;
                end else begin
                    alu_src_q <= dec.alu_src;
                    op_q      <= dec.op;
                    mem2reg_q <= dec.mem2reg;
                end
            end
            if (state_q == S_EXEC) zero_q <= bus.zero;
            if (state_q == S_WB)   pc_q   <= pc_nxt;
            regwrite_q <= (state_d == S_WB) && dec.regwr_en;
            memread_q  <= ((state_d == S_MEM) || (state_d == S_WB)) && dec.is_lw;
            memwrite_q <= (state_d == S_MEM) && dec.is_sw;
            retired_q  <= (state_d == S_WB);
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.RegWrite = regwrite_q;
    assign bus.ALUSrc   = alu_src_q;
    assign bus.MemRead  = memread_q;
    assign bus.MemWrite = memwrite_q;
    assign bus.Mem2Reg  = mem2reg_q;
    assign bus.op       = op_q;
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_y_ctrl_fsm.sv
// Self-checking bench for y_ctrl_fsm: directed program plus randomized
// instruction stream checked against a per-instruction reference model.
module tb_y_ctrl_fsm;
    import y_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_pc;

    y_ctrl_fsm_if #(.XLEN(32)) bus ();

    y_ctrl_fsm #(.XLEN(32), .ENTRY_PC(32'h28)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = 32'h28;
    endtask

    task automatic wait_fetch();
        for (int n = 0; n < 8 && bus.state != 3'(S_FETCH); n++) @(negedge clk);
        chk("fetch_wait", 32'(bus.state), 32'(S_FETCH));
    endtask

    // Runs one instruction starting at a FETCH and checks every cycle against the model.
    task automatic do_instr(input logic [31:0] i, input logic [31:0] im, input logic [31:0] jt,
                            input logic z, input bit drop_run);
        logic [6:0] opc;
        logic [2:0] f3, eop;
        bit is_r, is_lw, is_sw, is_beq, is_jal, wr, esrc;
        int lat;
        state_t est;
        opc = i[6:0];
        f3  = i[14:12];
        is_r = (opc == 7'h33); is_lw = (opc == 7'h03); is_sw = (opc == 7'h23);
        is_beq = (opc == 7'h63); is_jal = (opc == 7'h6F);
        wr   = is_r || is_lw || is_jal || (opc == 7'h13);
        esrc = !(is_r || is_beq);
        lat  = (is_lw || is_sw) ? 5 : 4;
        if (is_beq)                   eop = 3'b110;
        else if (is_r && f3 == 3'd6)  eop = 3'b001;
        else if (is_r && f3 == 3'd7)  eop = 3'b000;
        else                          eop = 3'b010;

        bus.ins = i; bus.imm = im; bus.jTarget = jt; bus.zero = z; bus.run = 1'b1;
        wait_fetch();
        for (int k = 0; k < lat; k++) begin
            if (k == 1 && drop_run) bus.run = 1'b0;
            if (k == 0)            est = S_FETCH;
            else if (k == 1)       est = S_DECODE;
            else if (k == 2)       est = S_EXEC;
            else if (k == lat - 1) est = S_WB;
            else                   est = S_MEM;
            chk("state",    32'(bus.state),    32'(est));
            chk("RegWrite", 32'(bus.RegWrite), 32'(wr && k == lat - 1));
            chk("MemRead",  32'(bus.MemRead),  32'(is_lw && k >= 3));
            chk("MemWrite", 32'(bus.MemWrite), 32'(is_sw && k == 3));
            chk("retired",  32'(bus.retired),  32'(k == lat - 1));
            if (k >= 2) begin
                chk("ALUSrc",  32'(bus.ALUSrc),  32'(esrc));
                chk("op",      32'(bus.op),      32'(eop));
                chk("Mem2Reg", 32'(bus.Mem2Reg), 32'(is_lw));
            end
            if (k >= 1) chk("ir", bus.ir, i);
            @(negedge clk);
        end
        if (is_beq && z)  model_pc = model_pc + (im << 1);
        else if (is_jal)  model_pc = model_pc + (jt << 2);
        else              model_pc = model_pc + 32'd4;
        chk("pc", bus.pc, model_pc);
        chk("retired_off", 32'(bus.retired), 32'd0);
        chk("after_state", 32'(bus.state), drop_run ? 32'(S_IDLE) : 32'(S_FETCH));
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0] opcs [8];
        opcs = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63, 7'h6F};
        bus.run = 1'b0; bus.ins = '0; bus.imm = '0; bus.jTarget = '0; bus.zero = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pc",    bus.pc, 32'h28);
        chk("rst_ir",    bus.ir, 32'h0);
        chk("rst_state", 32'(bus.state), 32'(S_IDLE));
        chk("rst_src",   32'(bus.ALUSrc), 32'd1);
        chk("rst_op",    32'(bus.op), 32'b010);
        chk("rst_strb",  32'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.retired, bus.illegal}), 32'd0);
        rst_n = 1'b1;
        model_pc = 32'h28;
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(bus.state), 32'(S_IDLE));

        do_instr(32'h002081B3, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("add_pc", bus.pc, 32'h2C);
        do_instr(32'h0020E1B3, 32'h0, 32'h0, 1'b0, 1'b0);
        do_instr(32'h0020F1B3, 32'h0, 32'h0, 1'b0, 1'b0);
        do_instr(32'h0000A183, 32'h0, 32'h0, 1'b0, 1'b0);
        do_instr(32'h0030A023, 32'h0, 32'h0, 1'b0, 1'b1);

        do_reset();
        do_instr(32'h00208463, 32'd4, 32'h0, 1'b1, 1'b1);
        chk("beq_taken_pc", bus.pc, 32'h30);
        do_reset();
        do_instr(32'h00208463, 32'd4, 32'h0, 1'b0, 1'b1);
        chk("beq_not_pc", bus.pc, 32'h2C);
        do_reset();
        do_instr(32'h0000006F, 32'h0, 32'd3, 1'b0, 1'b1);
        chk("jal_pc", bus.pc, 32'h34);

        do_reset();
        for (int t = 0; t < 40; t++) begin
            r = $urandom();
            r[6:0] = opcs[$urandom_range(0, 7)];
            do_instr(r, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        do_reset();
        bus.ins = 32'h0000007F; bus.run = 1'b1;
        wait_fetch();
        for (int k = 0; k < 10; k++) begin
            chk("halt_strb", 32'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.retired}), 32'd0);
            @(negedge clk);
        end
        chk("illegal",    32'(bus.illegal), 32'd1);
        chk("halt_state", 32'(bus.state), 32'(S_HALT));
        chk("halt_pc",    bus.pc, 32'h28);

        do_reset();
        bus.ins = 32'h002081B3; bus.run = 1'b1;
        wait_fetch();
        @(negedge clk);
        @(negedge clk);
        chk("midop_exec", 32'(bus.state), 32'(S_EXEC));
        rst_n = 1'b0;
        bus.run = 1'b0;
        #1;
        chk("midop_state", 32'(bus.state), 32'(S_IDLE));
        chk("midop_pc",    bus.pc, 32'h28);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("midop_nowr", 32'({bus.RegWrite, bus.retired}), 32'd0);
            @(negedge clk);
        end
        chk("midop_idle", 32'(bus.state), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/y_ctrl_fsm.md
Name: y_ctrl_fsm

Overview:
Multi-cycle control sequencer that sits upstream of the yIF/yID/yEX/yDM/yWB datapath.
- Owns the PC register and the instruction register.
- Decodes the RV32 opcode subset and drives the datapath control signals on a per-phase schedule.
- Computes the next PC from the branch/jump results returned by yID/yEX.
- Replaces the open-coded control and next-PC logic currently written in the testbench.

Parameters:
- ENTRY_PC, 32'h28: PC value loaded at reset.
- XLEN, 32: datapath and PC width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; while high the block keeps fetching instructions.
- ins  in  XLEN  instruction word from yIF for the current pc.
- imm  in  XLEN  sign-extended immediate from yID.
- jTarget  in  XLEN  jump offset from yID.
- zero  in  1  ALU zero flag from yEX.
- pc  out  XLEN  fetch address to yIF PCin.
- ir  out  XLEN  latched instruction.
- RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1 each  datapath controls.
- op  out  3  ALU operation to yEX.
- state  out  3  current FSM state, for debug.
- retired  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky; set on an unknown opcode.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=ENTRY_PC, ir=0, state=IDLE.
  - RegWrite=MemRead=MemWrite=Mem2Reg=0, ALUSrc=1, op=3'b010.
  - retired=0, illegal=0.
  - Reset asserted mid-instruction aborts it; no further write strobes follow.
- All outputs are registered. State encodings: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH when run=1.
- FETCH: ir<=ins. Next state DECODE.
- DECODE: decode ir[6:0] and set ALUSrc, op and Mem2Reg; these hold through WB.
  - 0x33 R-type: ALUSrc=0, op=010. If funct3=110, op=001. If funct3=111, op=000.
  - 0x13 addi: ALUSrc=1, op=010.
  - 0x03 lw: ALUSrc=1, op=010, Mem2Reg=1.
  - 0x23 sw: ALUSrc=1, op=010.
  - 0x63 beq: ALUSrc=0, op=110.
  - 0x6F jal: ALUSrc=1, op=010.
  - Any other opcode: illegal<=1, next state HALT.
- EXEC: zero_q<=zero, sampled at the end of EXEC. Next state is MEM for lw/sw, otherwise WB.
- MEM:
  - lw: MemRead=1.
  - sw: MemWrite=1 for exactly this one cycle.
  - Next state WB.
- WB:
  - RegWrite=1 for exactly this cycle, for R-type, addi, lw and jal only.
  - MemRead stays 1 for lw.
  - pc update:
    - beq with zero_q=1: pc <= pc + (imm<<1).
    - jal: pc <= pc + (jTarget<<2).
    - otherwise: pc <= pc + 4.
  - All PC arithmetic is modulo 2^XLEN; wrap-around is silent.
  - retired=1 for this cycle.
  - Next state FETCH if run=1, else IDLE.
- Latency: 4 cycles for R-type/addi/beq/jal, 5 cycles for lw/sw (FETCH to WB inclusive).
- Strobes: RegWrite, MemWrite and retired are 0 outside the cycles stated above. MemRead is 0 outside MEM/WB of lw.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction lets the instruction complete.
- HALT: all strobes 0, pc and ir frozen. Only reset exits HALT.

Decomposition:
- Package y_ctrl_pkg holds:
  - state encodings;
  - opcode constants OP_R=7'h33, OP_ADDI=7'h13, OP_LW=7'h03, OP_SW=7'h23, OP_BEQ=7'h63, OP_JAL=7'h6F;
  - ALU op constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110.
- One combinational sub-module, y_ctrl_decode: maps opcode and funct3 to {ALUSrc, op, Mem2Reg, regwr_en, is_mem, is_lw, is_sw, is_beq, is_jal, illegal}.
- y_ctrl_fsm holds the state, pc, ir, zero_q and the output registers.

Test Plan:
- Reset and idle: hold rst_n=0 -> pc=0x28, state=IDLE, ALUSrc=1, op=010, all strobes 0. Release reset with run=0 -> stays IDLE.
- add: ins=0x002081B3, run=1 -> ALUSrc=0, op=010. RegWrite=1 only in the 4th cycle. retired pulses once, then pc=0x2C.
- or: ins=0x0020E1B3 -> op=001. and: funct3=111 -> op=000.
- lw: ins=0x0000A183 -> 5-cycle instruction. MemRead=1 in MEM and WB, Mem2Reg=1, RegWrite=1 in WB only.
- sw: ins=0x0030A023 -> MemWrite=1 in MEM only, RegWrite never asserts.
- Branch and jump from pc=0x28:
  - beq (0x00208463), imm=4, zero=1 -> pc=0x30.
  - Same beq with zero=0 -> pc=0x2C.
  - jal (0x0000006F), jTarget=3 -> pc=0x34.
- Illegal and reset mid-op:
  - ins=0x0000007F -> illegal=1, state=HALT, pc stays 0x28, no strobes, even with run held high.
  - rst_n pulsed low during EXEC of an add -> IDLE, pc=0x28, RegWrite never asserted.
